clock_timer_ctrl: RTL and testbench

- Parametrised HH:MM:SS real-time clock with time-setting mode and a multiplexed 6-digit 7-segment display driver.
- Time is held as BCD counters, so no divide or modulo logic is needed.
- All key inputs are synchronised and debounced inside the block; nothing is clocked by a key edge.
- Sits between the board push-buttons and the 7-seg/LED pins; top level is fully synchronous to clk.

---
 rtl/timer_pkg.sv | 58 +++++
 rtl/key_debounce.sv | 45 ++++
 rtl/clock_timer_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_clock_timer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM:SS clock/timer block:
// FSM states, BCD time word, 7-segment patterns and digit one-hots.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_SET_H = 2'd2,
        ST_SET_M = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] h_t;
        logic [3:0] h_u;
        logic [3:0] m_t;
        logic [3:0] m_u;
        logic [3:0] s_t;
        logic [3:0] s_u;
    } time_t;

    // Active-low segments, bit order {dp, g, f, e, d, c, b, a}
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] DP_ON     = 8'h7F;

    localparam logic [5:0] DIGIT_1 = 6'b000001;
    localparam logic [5:0] DIGIT_2 = 6'b000010;
    localparam logic [5:0] DIGIT_3 = 6'b000100;
    localparam logic [5:0] DIGIT_4 = 6'b001000;
    localparam logic [5:0] DIGIT_5 = 6'b010000;
    localparam logic [5:0] DIGIT_6 = 6'b100000;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-FF synchroniser, stable-level debouncer and
// a one-cycle press pulse on each accepted 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1;
    logic             sync2;
    logic             lvl;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            lvl   <= 1'b1;
            lvl_d <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            lvl_d <= lvl;
            press <= lvl_d & ~lvl;
            // Any return to the accepted level restarts the stability window
            if (sync2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                lvl <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_timer_ctrl.sv
// HH:MM:SS BCD clock with set modes and a 6-digit multiplexed 7-seg driver.
// Optional countdown with done flag is enabled by defining TIMER_COUNTDOWN_EN.
module clock_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int BLINK_DIV    = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode_n,
    input  logic       key_inc_n,
    input  logic       key_pause_n,
`ifdef TIMER_COUNTDOWN_EN
    input  logic       count_down,
    output logic       done,
`endif
    output logic [7:0] seg,
    output logic [5:0] digit_sel,
    output logic [2:0] state_led,
    output logic       sec_pulse
);

    localparam int PRE_W   = $clog2(TICK_DIV + 1);
    localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    state_t             state;
    time_t              tm;
    time_t              tm_nxt;
    logic [PRE_W-1:0]   presc;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;
    logic               mode_p, inc_p, pause_p;
    logic               tick, tick_acc, leave_set, scan_wrap;
    logic [5:0]         sel_nxt;
    logic [7:0]         seg_nxt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode  (.clk(clk), .rst(rst), .key_n(key_mode_n),  .press(mode_p));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_inc   (.clk(clk), .rst(rst), .key_n(key_inc_n),   .press(inc_p));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_pause (.clk(clk), .rst(rst), .key_n(key_pause_n), .press(pause_p));

    function automatic time_t inc_hours(input time_t t);
        time_t r;
        r = t;
        if (r.h_t == 4'd2 && r.h_u == 4'd3) begin
            r.h_t = 4'd0;
            r.h_u = 4'd0;
        end else if (r.h_u == 4'd9) begin
            r.h_u = 4'd0;
            r.h_t = r.h_t + 4'd1;
        end else begin
            r.h_u = r.h_u + 4'd1;
        end
        return r;
    endfunction

    function automatic time_t inc_minutes(input time_t t);
        time_t r;
        r = t;
        if (r.m_u != 4'd9) begin
            r.m_u = r.m_u + 4'd1;
        end else begin
            r.m_u = 4'd0;
            r.m_t = (r.m_t == 4'd5) ? 4'd0 : r.m_t + 4'd1;
        end
        return r;
    endfunction

    function automatic time_t tick_up(input time_t t);
        time_t r;
        r = t;
        if (r.s_u != 4'd9) begin
            r.s_u = r.s_u + 4'd1;
        end else begin
            r.s_u = 4'd0;
            if (r.s_t != 4'd5) begin
                r.s_t = r.s_t + 4'd1;
            end else begin
                r.s_t = 4'd0;
                if (r.m_t == 4'd5 && r.m_u == 4'd9) r = inc_hours(r);
                r = inc_minutes(r);
            end
        end
        return r;
    endfunction

`ifdef TIMER_COUNTDOWN_EN
    // Only called with a non-zero time, so the hour borrow never underflows
    function automatic time_t tick_down(input time_t t);
        time_t r;
        r = t;
        if (r.s_u != 4'd0) r.s_u = r.s_u - 4'd1;
        else begin
            r.s_u = 4'd9;
            if (r.s_t != 4'd0) r.s_t = r.s_t - 4'd1;
            else begin
                r.s_t = 4'd5;
                if (r.m_u != 4'd0) r.m_u = r.m_u - 4'd1;
                else begin
                    r.m_u = 4'd9;
                    if (r.m_t != 4'd0) r.m_t = r.m_t - 4'd1;
                    else begin
                        r.m_t = 4'd5;
                        if (r.h_u != 4'd0) r.h_u = r.h_u - 4'd1;
                        else begin
                            r.h_u = 4'd9;
                            r.h_t = r.h_t - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    assign tick_acc = tick & ~done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) done <= 1'b0;
        else if (mode_p) done <= 1'b0;
        else if (tick_acc && count_down && (tm == time_t'(24'h000001) || tm == time_t'(24'h0)))
            done <= 1'b1;
    end
`else
    assign tick_acc = tick;
`endif

    assign tick      = (state == ST_RUN) && (presc == PRE_W'(TICK_DIV - 1));
    assign leave_set = mode_p && (state == ST_SET_M);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            state_led <= 3'b001;
        end else if (mode_p) begin
            case (state)
                ST_SET_H: begin state <= ST_SET_M; state_led <= 3'b100; end
                ST_SET_M: begin state <= ST_RUN;   state_led <= 3'b001; end
                default:  begin state <= ST_SET_H; state_led <= 3'b010; end
            endcase
        end else if (pause_p) begin
            if (state == ST_RUN)        state <= ST_PAUSE;
            else if (state == ST_PAUSE) state <= ST_RUN;
        end
    end

    always_comb begin
        tm_nxt = tm;
        if (leave_set) begin
            tm_nxt.s_t = 4'd0;
            tm_nxt.s_u = 4'd0;
        end else if (state == ST_SET_H && inc_p) begin
            tm_nxt = inc_hours(tm);
        end else if (state == ST_SET_M && inc_p) begin
            tm_nxt = inc_minutes(tm);
        end else if (tick_acc) begin
`ifdef TIMER_COUNTDOWN_EN
            if (count_down) tm_nxt = (tm == time_t'(24'h0)) ? tm : tick_down(tm);
            else            tm_nxt = tick_up(tm);
`else
            tm_nxt = tick_up(tm);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm        <= '0;
            presc     <= '0;
            sec_pulse <= 1'b0;
        end else begin
            tm        <= tm_nxt;
            sec_pulse <= tick_acc;
            if (leave_set)             presc <= '0;
            else if (tick)             presc <= '0;
            else if (state == ST_RUN)  presc <= presc + 1'b1;
        end
    end

    // Display: seg is loaded with the pattern of the digit being selected
    assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign sel_nxt   = {digit_sel[4:0], digit_sel[5]};

    always_comb begin
        seg_nxt = SEG_BLANK;
        case (sel_nxt)
            DIGIT_1: seg_nxt = bcd_to_seg(tm.s_u);
            DIGIT_2: seg_nxt = bcd_to_seg(tm.s_t);
            DIGIT_3: seg_nxt = bcd_to_seg(tm.m_u) & DP_ON;
            DIGIT_4: seg_nxt = bcd_to_seg(tm.m_t);
            DIGIT_5: seg_nxt = bcd_to_seg(tm.h_u) & DP_ON;
            DIGIT_6: seg_nxt = bcd_to_seg(tm.h_t);
            default: seg_nxt = SEG_BLANK;
        endcase
        if (blink_ph && state == ST_SET_H && (sel_nxt == DIGIT_5 || sel_nxt == DIGIT_6))
            seg_nxt = SEG_BLANK;
        if (blink_ph && state == ST_SET_M && (sel_nxt == DIGIT_3 || sel_nxt == DIGIT_4))
            seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            digit_sel <= DIGIT_1;
            seg       <= SEG_BLANK;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_sel <= sel_nxt;
            seg       <= seg_nxt;
        end else begin
            scan_cnt  <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_timer_ctrl.sv
// Directed bench for clock_timer_ctrl with small dividers so every
// timing relation can be counted by hand.
module tb_clock_timer_ctrl;
    import timer_pkg::*;

    localparam int TICK_DIV     = 4;
    localparam int SCAN_DIV     = 2;
    localparam int DEBOUNCE_CYC = 2;
    localparam int BLINK_DIV    = 8;
    localparam int K_MODE  = 0;
    localparam int K_INC   = 1;
    localparam int K_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode_n = 1'b1;
    logic       key_inc_n = 1'b1;
    logic       key_pause_n = 1'b1;
    logic [7:0] seg;
    logic [5:0] digit_sel;
    logic [2:0] state_led;
    logic       sec_pulse;
`ifdef TIMER_COUNTDOWN_EN
    logic       count_down = 1'b0;
    logic       done;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    clock_timer_ctrl #(
        .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst),
        .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_pause_n(key_pause_n),
`ifdef TIMER_COUNTDOWN_EN
        .count_down(count_down), .done(done),
`endif
        .seg(seg), .digit_sel(digit_sel), .state_led(state_led), .sec_pulse(sec_pulse)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_MODE:  key_mode_n  = v;
            K_INC:   key_inc_n   = v;
            default: key_pause_n = v;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b0);
        cyc(8);
        set_key(k, 1'b1);
        cyc(6);
    endtask

    // Returns on the negedge where rst is released: zero posedges since release
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        key_mode_n = 1'b1; key_inc_n = 1'b1; key_pause_n = 1'b1;
        cyc(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] t;
        cyc(2);
        t = dut.tm;
        n_total++; if (digit_sel !== 6'b000001) $display("FAIL reset_digit_sel got %b want 000001", digit_sel); else n_pass++;
        n_total++; if (seg !== 8'hFF) $display("FAIL reset_seg got %h want ff", seg); else n_pass++;
        n_total++; if (state_led !== 3'b001) $display("FAIL reset_state_led got %b want 001", state_led); else n_pass++;
        n_total++; if (sec_pulse !== 1'b0) $display("FAIL reset_sec_pulse got %b want 0", sec_pulse); else n_pass++;
        n_total++; if (t !== 24'h000000) $display("FAIL reset_time got %h want 000000", t); else n_pass++;
        rst = 1'b1;
        cyc(3);
        n_total++; if (digit_sel !== 6'b000010) $display("FAIL first_scan_step got %b want 000010", digit_sel); else n_pass++;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_total++; if (digit_sel !== 6'b000001) $display("FAIL async_reset_digit_sel got %b want 000001", digit_sel); else n_pass++;
        n_total++; if (seg !== 8'hFF) $display("FAIL async_reset_seg got %h want ff", seg); else n_pass++;
    endtask

    task automatic test_run_minute();
        int pulses = 0, last = -1, first = -1, bad_gap = 0, bad_width = 0;
        logic prev = 1'b0;
        logic [23:0] t;
        do_reset();
        for (int i = 1; i <= 240; i++) begin
            cyc(1);
            if (sec_pulse === 1'b1) begin
                pulses++;
                if (prev) bad_width++;
                if (first < 0) first = i;
                if (last >= 0 && i - last != 4) bad_gap++;
                last = i;
            end
            prev = sec_pulse;
        end
        t = dut.tm;
        n_total++; if (pulses != 60) $display("FAIL run_pulse_count got %0d want 60", pulses); else n_pass++;
        n_total++; if (first != 4) $display("FAIL run_first_pulse got cycle %0d want 4", first); else n_pass++;
        n_total++; if (bad_gap != 0) $display("FAIL run_pulse_gap got %0d bad gaps want 0", bad_gap); else n_pass++;
        n_total++; if (bad_width != 0) $display("FAIL run_pulse_width got %0d wide pulses want 0", bad_width); else n_pass++;
        n_total++; if (t !== 24'h000100) $display("FAIL run_minute_time got %h want 000100", t); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [23:0] t;
        do_reset();
        press(K_MODE);
        repeat (23) press(K_INC);
        press(K_MODE);
        repeat (59) press(K_INC);
        n_total++; if (state_led !== 3'b100) $display("FAIL wrap_set_m_led got %b want 100", state_led); else n_pass++;
        press(K_MODE);
        t = dut.tm;
        n_total++; if (t !== 24'h235902) $display("FAIL wrap_after_set got %h want 235902", t); else n_pass++;
        cyc(228);
        t = dut.tm;
        n_total++; if (t !== 24'h235959) $display("FAIL wrap_pre got %h want 235959", t); else n_pass++;
        cyc(4);
        t = dut.tm;
        n_total++; if (t !== 24'h000000) $display("FAIL wrap_midnight got %h want 000000", t); else n_pass++;
        n_total++; if (sec_pulse !== 1'b1) $display("FAIL wrap_sec_pulse got %b want 1", sec_pulse); else n_pass++;
        n_total++; if (state_led !== 3'b001) $display("FAIL wrap_state_led got %b want 001", state_led); else n_pass++;
        cyc(1);
        n_total++; if (sec_pulse !== 1'b0) $display("FAIL wrap_pulse_width got %b want 0", sec_pulse); else n_pass++;
    endtask

    task automatic test_pause();
        logic [23:0] t;
        int moved = 0, pulses = 0;
        do_reset();
        cyc(4);
        t = dut.tm;
        n_total++; if (t !== 24'h000001) $display("FAIL pause_start got %h want 000001", t); else n_pass++;
        set_key(K_PAUSE, 1'b0);
        cyc(8);
        set_key(K_PAUSE, 1'b1);
        t = dut.tm;
        n_total++; if (t !== 24'h000002) $display("FAIL pause_frozen got %h want 000002", t); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (dut.tm !== 24'h000002) moved++;
            if (sec_pulse === 1'b1) pulses++;
        end
        n_total++; if (moved != 0 || pulses != 0) $display("FAIL pause_hold got %0d changes %0d pulses want 0 0", moved, pulses); else n_pass++;
        set_key(K_PAUSE, 1'b0);
        cyc(7);
        t = dut.tm;
        n_total++; if (t !== 24'h000002) $display("FAIL resume_early got %h want 000002", t); else n_pass++;
        cyc(1);
        t = dut.tm;
        n_total++; if (t !== 24'h000003) $display("FAIL resume_tick got %h want 000003", t); else n_pass++;
        n_total++; if (sec_pulse !== 1'b1) $display("FAIL resume_pulse got %b want 1", sec_pulse); else n_pass++;
        set_key(K_PAUSE, 1'b1);
        cyc(6);
    endtask

    task automatic test_set_time();
        logic [23:0] t;
        do_reset();
        press(K_MODE);
        n_total++; if (state_led !== 3'b010) $display("FAIL set_h_led got %b want 010", state_led); else n_pass++;
        repeat (25) press(K_INC);
        t = dut.tm;
        n_total++; if (t !== 24'h010001) $display("FAIL set_hours got %h want 010001", t); else n_pass++;
        press(K_MODE);
        repeat (61) press(K_INC);
        t = dut.tm;
        n_total++; if (t !== 24'h010101) $display("FAIL set_minutes got %h want 010101", t); else n_pass++;
        set_key(K_MODE, 1'b0);
        cyc(6);
        t = dut.tm;
        n_total++; if (t !== 24'h010100) $display("FAIL leave_clears_sec got %h want 010100", t); else n_pass++;
        n_total++; if (state_led !== 3'b001) $display("FAIL leave_led got %b want 001", state_led); else n_pass++;
        cyc(3);
        t = dut.tm;
        n_total++; if (t !== 24'h010100) $display("FAIL leave_no_early_tick got %h want 010100", t); else n_pass++;
        cyc(1);
        t = dut.tm;
        n_total++; if (t !== 24'h010101) $display("FAIL leave_first_tick got %h want 010101", t); else n_pass++;
        set_key(K_MODE, 1'b1);
        cyc(6);
        press(K_INC);
        t = dut.tm;
        n_total++; if (t !== 24'h010106) $display("FAIL inc_in_run got %h want 010106", t); else n_pass++;
    endtask

    task automatic test_keys_glitch();
        logic [23:0] t;
        do_reset();
        press(K_MODE);
        key_inc_n = 1'b0;
        cyc(1);
        key_inc_n = 1'b1;
        cyc(10);
        t = dut.tm;
        n_total++; if (t[23:16] !== 8'h00) $display("FAIL glitch_hours got %h want 00", t[23:16]); else n_pass++;
        key_inc_n = 1'b0;
        cyc(40);
        key_inc_n = 1'b1;
        cyc(6);
        t = dut.tm;
        n_total++; if (t[23:16] !== 8'h01) $display("FAIL hold_one_pulse got %h want 01", t[23:16]); else n_pass++;
        press(K_PAUSE);
        n_total++; if (state_led !== 3'b010) $display("FAIL pause_in_set got %b want 010", state_led); else n_pass++;
        do_reset();
        key_mode_n = 1'b0; key_pause_n = 1'b0;
        cyc(8);
        key_mode_n = 1'b1; key_pause_n = 1'b1;
        cyc(6);
        n_total++; if (state_led !== 3'b010) $display("FAIL mode_beats_pause got %b want 010", state_led); else n_pass++;
    endtask

    task automatic test_scan_blink();
        logic [23:0] t;
        logic [7:0]  exp_seg [6] = '{8'h82, 8'h92, 8'h19, 8'hB0, 8'h24, 8'hF9};
        logic [5:0]  one = 6'b000001;
        int blank_h = 0, shown_h = 0, bad = 0, w;
        do_reset();
        press(K_MODE);
        repeat (12) press(K_INC);
        for (int i = 0; i < 96; i++) begin
            cyc(1);
            case (digit_sel)
                6'b100000: if (seg === 8'hFF) blank_h++; else if (seg === 8'hF9) shown_h++; else bad++;
                6'b010000: if (seg === 8'hFF) blank_h++; else if (seg === 8'h24) shown_h++; else bad++;
                6'b001000: if (seg !== 8'hC0) bad++;
                6'b000100: if (seg !== 8'h40) bad++;
                default: ;
            endcase
        end
        n_total++; if (bad != 0) $display("FAIL blink_patterns got %0d bad want 0", bad); else n_pass++;
        n_total++; if (blank_h == 0) $display("FAIL blink_blank_seen got %0d want >0", blank_h); else n_pass++;
        n_total++; if (shown_h == 0) $display("FAIL blink_digit_seen got %0d want >0", shown_h); else n_pass++;
        press(K_MODE);
        repeat (34) press(K_INC);
        press(K_MODE);
        t = dut.tm;
        n_total++; if (t !== 24'h123402) $display("FAIL scan_setup got %h want 123402", t); else n_pass++;
        cyc(212);
        set_key(K_PAUSE, 1'b0);
        cyc(8);
        set_key(K_PAUSE, 1'b1);
        cyc(26);
        t = dut.tm;
        n_total++; if (t !== 24'h123456) $display("FAIL scan_time got %h want 123456", t); else n_pass++;
        w = 0;
        while (digit_sel !== 6'b000010 && w < 20) begin cyc(1); w++; end
        while (digit_sel !== 6'b000001 && w < 40) begin cyc(1); w++; end
        n_total++; if (w >= 40) $display("FAIL scan_align got timeout want digit 000001"); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            n_total++; if (digit_sel !== (one << (i % 6))) $display("FAIL scan_sel_%0d got %b want %b", i, digit_sel, one << (i % 6)); else n_pass++;
            n_total++; if (seg !== exp_seg[i % 6]) $display("FAIL scan_seg_%0d got %h want %h", i, seg, exp_seg[i % 6]); else n_pass++;
            cyc(2);
        end
    endtask

    initial begin
        test_reset();
        test_run_minute();
        test_wrap();
        test_pause();
        test_set_time();
        test_keys_glitch();
        test_scan_blink();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
